// File: rtl/pio_button_in.sv
// Avalon-MM input PIO for board push-buttons and switches.
// Each input is synchronized, debounced, edge-detected and latched into an
// edge-capture register that can raise a maskable level interrupt.
module pio_button_in #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [CW-1:0]    db_cnt [WIDTH];
    logic             wr_en;
    logic             rd_en;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Two-flop synchronizer for the asynchronous board inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= {WIDTH{IDLE_LEVEL}};
            sync2 <= {WIDTH{IDLE_LEVEL}};
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= {WIDTH{IDLE_LEVEL}};
            for (int unsigned i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced value for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= {WIDTH{IDLE_LEVEL}};
        end else begin
            prev <= stable;
        end
    end

    // Edge pulse selection: rising, falling or any transition.
    always_comb begin
        edge_pulse = '0;
        case (EDGE_TYPE)
            0:       edge_pulse = stable & ~prev;
            1:       edge_pulse = ~stable & prev;
            default: edge_pulse = stable ^ prev;
        endcase
    end

    // Edge capture: write-one-to-clear, with a same-cycle edge taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else if (wr_en && (reg_addr_e'(address) == REG_EDGE)) begin
            edge_capture <= (edge_capture & ~writedata) | edge_pulse;
        end else begin
            edge_capture <= edge_capture | edge_pulse;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_en && (reg_addr_e'(address) == REG_MASK)) begin
            irq_mask <= writedata;
        end
    end

    // Registered read data with one cycle latency; holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (reg_addr_e'(address))
                REG_DATA: readdata <= stable;
                REG_RSVD: readdata <= '0;
                REG_MASK: readdata <= irq_mask;
                REG_EDGE: readdata <= edge_capture;
                default:  readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
